// File: rtl/rvfi_serializer.sv
// rtl/rvfi_serializer.sv - serializes multi-lane RVFI retirements into one channel
//
// Purpose: collects up to NRET retirement records per cycle, compacts the
// valid lanes in lane order into a DEPTH-entry FIFO and presents one record
// per cycle to a single-channel instruction checker. Records that do not fit
// are dropped and flagged by a sticky overflow bit.
//
// Optional feature: define RISCV_FORMAL_SERIALIZER_BYPASS_EN to forward the
// lowest valid lane straight to the output while the FIFO is empty.
//
// Ports:
//   clk       in   1            clock, rising edge
//   reset     in   1            synchronous, active-high
//   in_valid  in   NRET         per-lane retirement strobe, lane 0 oldest
//   in_rec    in   NRET*REC_W   per-lane record, lane i at [i*REC_W +: REC_W]
//   out_valid out  1            serialized retirement strobe
//   out_rec   out  REC_W        serialized record, zero when out_valid=0
//   count     out  CW           FIFO occupancy
//   overflow  out  1            sticky: a record has been dropped

`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 2
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module rvfi_serializer #(
  parameter  int DEPTH = 8,
  localparam int NRET  = `RISCV_FORMAL_NRET,
  localparam int XLEN  = `RISCV_FORMAL_XLEN,
  localparam int REC_W = 48 + 5 * XLEN,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRET-1:0]        in_valid,
  input  logic [NRET*REC_W-1:0]  in_rec,
  output logic                   out_valid,
  output logic [REC_W-1:0]       out_rec,
  output logic [CW-1:0]          count,
  output logic                   overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int FW = CW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_pop;
  logic [FW-1:0]    w_free;
  logic [FW-1:0]    w_acc;
  logic             w_drop;
  logic [NRET-1:0]  w_wr_en;
  logic [AW-1:0]    w_wr_idx [NRET];
  logic             w_byp;
  logic [LW-1:0]    w_byp_lane;

`ifdef RISCV_FORMAL_SERIALIZER_BYPASS_EN
  // Empty FIFO: the oldest valid lane goes straight out and is never stored.
  always_comb begin
    w_byp      = (r_count == '0) && (|in_valid);
    w_byp_lane = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (in_valid[i]) w_byp_lane = LW'(i);
    end
  end
`else
  assign w_byp      = 1'b0;
  assign w_byp_lane = '0;
`endif

  // The head record is always consumed, so its slot counts as free this cycle.
  assign w_pop  = (r_count != '0);
  assign w_free = DEPTH_F - {1'b0, r_count} + {{CW{1'b0}}, w_pop};

  // Compaction: the k-th accepted lane lands at wr_ptr+k; lanes beyond the
  // free space are dropped, so lower lanes always win.
  always_comb begin
    w_acc   = '0;
    w_drop  = 1'b0;
    w_wr_en = '0;
    for (int i = 0; i < NRET; i++) begin
      w_wr_idx[i] = '0;
      if (in_valid[i] && !(w_byp && (w_byp_lane == LW'(i)))) begin
        if (w_acc < w_free) begin
          w_wr_en[i]  = 1'b1;
          w_wr_idx[i] = r_wr_ptr + w_acc[AW-1:0];
          w_acc       = w_acc + FW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NRET; i++) begin
        if (w_wr_en[i]) r_mem[w_wr_idx[i]] <= in_rec[i*REC_W +: REC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_wr_ptr <= r_wr_ptr + w_acc[AW-1:0];
      r_count  <= r_count - CW'(w_pop) + w_acc[CW-1:0];
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_valid = w_pop | w_byp;
  assign count     = r_count;
  assign overflow  = r_overflow;

  always_comb begin
    out_rec = '0;
    if (w_pop) begin
      out_rec = r_mem[r_rd_ptr];
    end else if (w_byp) begin
      out_rec = in_rec[w_byp_lane*REC_W +: REC_W];
    end
  end

endmodule

// File: tb/tb_rvfi_serializer.sv
// tb/tb_rvfi_serializer.sv - self-checking bench for rvfi_serializer
//
// Purpose: drives directed and random retirement traffic into a DEPTH=4,
// NRET=2, XLEN=32 serializer and compares every cycle against a queue model.
// Honours RISCV_FORMAL_SERIALIZER_BYPASS_EN when defined.
//
// Ports: none (top-level bench).

`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 2
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module tb_rvfi_serializer;

  localparam int DEPTH = 4;
  localparam int REC_W = 208;
  localparam int CW    = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           in_valid;
  logic [2*REC_W-1:0]   in_rec;
  logic                 out_valid;
  logic [REC_W-1:0]     out_rec;
  logic [CW-1:0]        count;
  logic                 overflow;

  int total = 0;
  int bad   = 0;

  logic [REC_W-1:0] q [$];
  logic             m_ovf;

  rvfi_serializer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_rec   (out_rec),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] mk_rec(
    logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] insn,
    logic [31:0] pre_pc, logic [31:0] pre_rs1, logic [31:0] pre_rs2,
    logic [31:0] post_pc, logic [31:0] post_rd, logic trap);
    return {trap, post_rd, post_pc, pre_rs2, pre_rs1, pre_pc, insn, rd, rs2, rs1};
  endfunction

  function automatic logic [REC_W-1:0] rnd_rec();
    return mk_rec(5'($urandom), 5'($urandom), 5'($urandom), $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom));
  endfunction

  task automatic chk(input string tag, input logic [REC_W-1:0] got,
                     input logic [REC_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive lanes, check outputs against the model, advance model.
  task automatic step(input logic [1:0] v, input logic [REC_W-1:0] r0,
                      input logic [REC_W-1:0] r1);
    logic             ev;
    logic [REC_W-1:0] er;
    int               bl;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = v;
    in_rec   = {r1, r0};
    #1;
    ev = 1'b0;
    er = '0;
    bl = -1;
    if (q.size() > 0) begin
      ev = 1'b1;
      er = q[0];
    end
`ifdef RISCV_FORMAL_SERIALIZER_BYPASS_EN
    else if (v != 2'b00) begin
      ev = 1'b1;
      bl = v[0] ? 0 : 1;
      er = (bl == 0) ? r0 : r1;
    end
`endif
    chk("out_valid", out_valid, ev);
    chk("out_rec",   out_rec,   er);
    chk("count",     count,     q.size());
    chk("overflow",  overflow,  m_ovf);
    if (q.size() > 0) void'(q.pop_front());
    if (v[0] && bl != 0) begin
      if (q.size() < DEPTH) q.push_back(r0); else m_ovf = 1'b1;
    end
    if (v[1] && bl != 1) begin
      if (q.size() < DEPTH) q.push_back(r1); else m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = v;
    in_rec   = {rnd_rec(), rnd_rec()};
    q.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [REC_W-1:0] r_a;
    logic [REC_W-1:0] r_b;
    reset    = 1'b1;
    in_valid = '0;
    in_rec   = '0;
    m_ovf    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    step(2'b00, '0, '0);

    // Single lane-0 retirement
    r_a = mk_rec(5'd0, 5'd0, 5'd1, 32'h00500093, 32'h0, 32'h0, 32'h0,
                 32'h4, 32'h5, 1'b0);
    step(2'b01, r_a, rnd_rec());
    step(2'b00, '0, '0);
    step(2'b00, '0, '0);

    // Both lanes for three cycles, then drain
    repeat (3) step(2'b11, rnd_rec(), rnd_rec());
    repeat (6) step(2'b00, '0, '0);

    // Fill to four, then overflow, then hold across idle
    repeat (4) step(2'b11, rnd_rec(), rnd_rec());
    repeat (10) step(2'b00, '0, '0);

    // Lane 1 alone
    r_b = mk_rec(5'd2, 5'd3, 5'd4, 32'h00000013, 32'h100, 32'h1, 32'h2,
                 32'h104, 32'h0, 1'b0);
    step(2'b10, rnd_rec(), r_b);
    step(2'b00, '0, '0);
    step(2'b00, '0, '0);

    // Build count=3 with overflow set, then reset mid-operation
    repeat (2) step(2'b11, rnd_rec(), rnd_rec());
    do_reset(2'b01);
    repeat (3) step(2'b00, '0, '0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset(2'($urandom));
      else step(2'($urandom), rnd_rec(), rnd_rec());
    end
    repeat (6) step(2'b00, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
